// File: rtl/ram_arb_pkg.sv
//==============================================================================
// Module      : ram_arb_pkg
// Description : Shared constants, request record and round-robin pick helper
//               for the RAM arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ram_arb_pkg;

    localparam int DATA_W_C  = 16;
    localparam int ADDR_W_C  = 6;
    localparam int DEPTH_C   = 16;
    localparam int MAX_REQ_C = 4;
    localparam int PTR_W_C   = 2;

    typedef struct packed {
        logic                wr;
        logic [ADDR_W_C-1:0] addr;
        logic [DATA_W_C-1:0] wdata;
    } req_t;

    // One-hot winner: first set bit of valid scanning from ptr upward, modulo n.
    function automatic logic [MAX_REQ_C-1:0] rr_pick(
        input logic [MAX_REQ_C-1:0] valid,
        input logic [PTR_W_C-1:0]   ptr,
        input logic [2:0]           n
    );
        logic [MAX_REQ_C-1:0] grant;
        logic                 found;
        logic [2:0]           idx;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ_C; i++) begin
            idx = 3'(ptr) + 3'(i);
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (3'(i) < n) && valid[idx[1:0]]) begin
                grant[idx[1:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_rr_picker.sv
//==============================================================================
// Module      : rr_picker
// Description : Combinational rotate-priority-rotate-back encoder returning a
//               one-hot grant for up to four requesters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_picker
    import ram_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]   valid,
    input  logic [PTR_W_C-1:0] ptr,
    output logic [N_REQ-1:0]   grant
);

    logic [MAX_REQ_C-1:0] w_vin;
    logic [MAX_REQ_C-1:0] w_pick;
    logic                 w_unused_hi;

    always_comb begin
        w_vin              = '0;
        w_vin[N_REQ-1:0]   = valid;
    end

    assign w_pick      = rr_pick(w_vin, ptr, 3'(N_REQ));
    assign grant       = w_pick[N_REQ-1:0];
    // Upper pick bits are always zero when fewer than four requesters exist.
    assign w_unused_hi = ^w_pick;

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
//==============================================================================
// Module      : ram_arbiter
// Description : Round-robin arbiter sharing a simple dual-port RAM between
//               N_REQ requesters, routing 1-cycle read responses to owners.
//               Optional macro RAM_ARB_DUAL_ISSUE_EN: one write + one read/cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_C,
    parameter int ADDR_W = ADDR_W_C,
    parameter int DEPTH  = DEPTH_C,
    parameter int N_REQ  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0]          req_wr,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      ram_wr,
    output logic [DATA_W-1:0]         ram_dina,
    output logic [ADDR_W-1:0]         ram_addra,
    output logic [ADDR_W-1:0]         ram_addrb,
    input  logic [DATA_W-1:0]         ram_doutb
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    req_t               w_req [N_REQ];
    logic [N_REQ-1:0]   w_valid;
    logic [N_REQ-1:0]   w_wgnt;
    logic [N_REQ-1:0]   w_rgnt;
    req_t               w_wsel;
    req_t               w_rsel;
    logic [PTR_W_C-1:0] w_widx;
    logic [PTR_W_C-1:0] w_ridx;
    logic               w_wr_hs;
    logic               w_rd_hs;
    logic               w_wr_inrange;
    logic               w_rd_inrange;
    logic [2:0]         w_wdist;
    logic [2:0]         w_rdist;
    logic [PTR_W_C-1:0] w_adv_idx;
    logic [PTR_W_C-1:0] w_nxt_ptr;
    logic               w_unused;

    logic [PTR_W_C-1:0] r_rr_ptr;
    logic               r_rd_pend;
    logic [PTR_W_C-1:0] r_rd_owner;
    logic               r_rd_err;
    logic [ADDR_W-1:0]  r_addrb;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_req[i].wr    = req_wr[i];
            w_req[i].addr  = req_addr[i*ADDR_W +: ADDR_W];
            w_req[i].wdata = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // No grants while reset is held, even though the request inputs may be live.
    assign w_valid = rst ? '0 : req_valid;

`ifdef RAM_ARB_DUAL_ISSUE_EN
    logic [N_REQ-1:0] w_rd_cand;

    rr_picker #(.N_REQ(N_REQ)) u_wr_pick (
        .valid (w_valid & req_wr),
        .ptr   (r_rr_ptr),
        .grant (w_wgnt)
    );

    assign w_rd_cand = w_valid & ~req_wr & ~w_wgnt;

    rr_picker #(.N_REQ(N_REQ)) u_rd_pick (
        .valid (w_rd_cand),
        .ptr   (r_rr_ptr),
        .grant (w_rgnt)
    );
`else
    logic [N_REQ-1:0] w_gnt;

    rr_picker #(.N_REQ(N_REQ)) u_pick (
        .valid (w_valid),
        .ptr   (r_rr_ptr),
        .grant (w_gnt)
    );

    assign w_wgnt = w_gnt & req_wr;
    assign w_rgnt = w_gnt & ~req_wr;
`endif

    always_comb begin
        w_wsel = '0;
        w_rsel = '0;
        w_widx = '0;
        w_ridx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_wgnt[i]) begin
                w_wsel = w_req[i];
                w_widx = PTR_W_C'(i);
            end
            if (w_rgnt[i]) begin
                w_rsel = w_req[i];
                w_ridx = PTR_W_C'(i);
            end
        end
    end

    assign w_wr_hs      = |w_wgnt;
    assign w_rd_hs      = |w_rgnt;
    assign w_wr_inrange = {1'b0, w_wsel.addr} < c_depth;
    assign w_rd_inrange = {1'b0, w_rsel.addr} < c_depth;
    assign w_unused     = ^{w_wsel.wr, w_rsel.wr, w_rsel.wdata};

    assign req_ready = w_wgnt | w_rgnt;
    assign ram_wr    = w_wr_hs & w_wr_inrange;
    assign ram_addra = ram_wr ? w_wsel.addr  : '0;
    assign ram_dina  = ram_wr ? w_wsel.wdata : '0;
    assign ram_addrb = w_rd_hs ? w_rsel.addr : r_addrb;

    // Rotational distance from the pointer decides which winner had priority.
    always_comb begin
        w_wdist = 3'(w_widx) + 3'(N_REQ) - 3'(r_rr_ptr);
        if (w_wdist >= 3'(N_REQ)) begin
            w_wdist = w_wdist - 3'(N_REQ);
        end
        w_rdist = 3'(w_ridx) + 3'(N_REQ) - 3'(r_rr_ptr);
        if (w_rdist >= 3'(N_REQ)) begin
            w_rdist = w_rdist - 3'(N_REQ);
        end
        w_adv_idx = (w_wr_hs && (!w_rd_hs || (w_wdist < w_rdist))) ? w_widx : w_ridx;
        w_nxt_ptr = (w_adv_idx == PTR_W_C'(N_REQ-1)) ? '0 : w_adv_idx + PTR_W_C'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= '0;
            r_rd_err   <= 1'b0;
            r_addrb    <= '0;
        end else begin
            if (w_wr_hs || w_rd_hs) begin
                r_rr_ptr <= w_nxt_ptr;
            end
            r_rd_pend <= w_rd_hs;
            if (w_rd_hs) begin
                r_rd_owner <= w_ridx;
                r_rd_err   <= ~w_rd_inrange;
            end
            r_addrb <= ram_addrb;
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = r_rd_pend && (r_rd_owner == PTR_W_C'(i));
        end
    end

    assign rsp_err   = r_rd_pend & r_rd_err;
    assign rsp_rdata = (r_rd_pend && !r_rd_err) ? ram_doutb : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
//==============================================================================
// Module      : tb_ram_arbiter
// Description : Scoreboard bench for ram_arbiter with a behavioural 16x16 RAM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ram_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int N     = 2;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            ram_wr;
    logic [DW-1:0]   ram_dina;
    logic [AW-1:0]   ram_addra;
    logic [AW-1:0]   ram_addrb;
    logic [DW-1:0]   ram_doutb;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_wr    (ram_wr),
        .ram_dina  (ram_dina),
        .ram_addra (ram_addra),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb)
    );

    // Behavioural RAM: write port A, registered read port B, read-before-write.
    logic [DW-1:0] ram [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        ram_doutb = '0;
    end
    always @(posedge clk) begin
        if (ram_wr) ram[ram_addra[3:0]] <= ram_dina;
        ram_doutb <= ram[ram_addrb[3:0]];
    end

    // Requester-side drive state
    logic [N-1:0]  v = '0;
    logic [N-1:0]  w = '0;
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];

    assign req_valid = v;
    assign req_wr    = w;
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = a[i];
            req_wdata[i*DW +: DW] = d[i];
        end
    end

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic [31:0] err;
        int          cyc;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] m_mem [DEPTH];
    int            m_ptr = 0;
    logic [AW-1:0] m_addrb = '0;
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic put(input int r, input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
        v[r] = 1'b1;
        w[r] = wr;
        a[r] = ad;
        d[r] = dt;
    endtask

    // One bus cycle: predict grants, check the combinational outputs, queue reads.
    task automatic cycle();
        logic [N-1:0] eg;
        int           wi;
        int           ri;
        int           gi;
        int           pi;
        logic         exp_wr;
        exp_t         e;
        @(negedge clk);
        eg = '0;
        wi = -1;
        ri = -1;
`ifdef RAM_ARB_DUAL_ISSUE_EN
        wi = first_from(v & w, m_ptr);
        if (wi >= 0) eg[wi] = 1'b1;
        ri = first_from(v & ~w & ~eg, m_ptr);
        if (ri >= 0) eg[ri] = 1'b1;
`else
        gi = first_from(v, m_ptr);
        if (gi >= 0) begin
            eg[gi] = 1'b1;
            if (w[gi]) wi = gi;
            else       ri = gi;
        end
`endif
        check("req_ready", 32'(req_ready), 32'(eg));
        exp_wr = (wi >= 0) && (a[wi] < AW'(DEPTH));
        check("ram_wr", 32'(ram_wr), 32'(exp_wr));
        if (exp_wr) begin
            check("ram_addra", 32'(ram_addra), 32'(a[wi]));
            check("ram_dina", 32'(ram_dina), 32'(d[wi]));
        end
        if (ri >= 0) begin
            check("ram_addrb", 32'(ram_addrb), 32'(a[ri]));
            e.owner = ri;
            e.err   = (a[ri] >= AW'(DEPTH)) ? 32'd1 : 32'd0;
            e.data  = (e.err != 0) ? 32'd0 : 32'(m_mem[a[ri][3:0]]);
            e.cyc   = cyc;
            q.push_back(e);
            m_addrb = a[ri];
        end else begin
            check("ram_addrb_hold", 32'(ram_addrb), 32'(m_addrb));
        end
        if (exp_wr) m_mem[a[wi][3:0]] = d[wi];
        pi = first_from(eg, m_ptr);
        if (pi >= 0) m_ptr = (pi + 1) % N;
        @(posedge clk);
        #1;
        if (wi >= 0) v[wi] = 1'b0;
        if (ri >= 0) v[ri] = 1'b0;
    endtask

    task automatic run_until_idle();
        int n;
        n = 0;
        while (v != '0 && n < 20) begin
            cycle();
            n++;
        end
        if (v != '0) check("grant_timeout", 32'(v), 32'd0);
    endtask

    // Monitor: each response must land exactly one cycle after its handshake.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc + 1 == cyc) begin
            e = q.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(1) << e.owner);
            check("rsp_rdata", 32'(rsp_rdata), e.data);
            check("rsp_err", 32'(rsp_err), e.err);
        end else if (rsp_valid != '0) begin
            check("rsp_spurious", 32'(rsp_valid), 32'd0);
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        for (int i = 0; i < N; i++) begin
            a[i] = '0;
            d[i] = '0;
        end

        // Reset state with a live request that must not be granted
        put(0, 1'b1, 6'd1, 16'h5555);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_addra", 32'(ram_addra), 32'd0);
        check("rst_addrb", 32'(ram_addrb), 32'd0);
        check("rst_dina", 32'(ram_dina), 32'd0);
        @(posedge clk);
        #1;
        v = '0;
        rst = 1'b0;
        cycle();

        // Write then read
        put(0, 1'b1, 6'd3, 16'hBEEF);
        run_until_idle();
        put(0, 1'b0, 6'd3, 16'h0);
        run_until_idle();
        put(1, 1'b1, 6'd7, 16'h7777);
        run_until_idle();

        // Fairness: both hold reads continuously
        for (int k = 0; k < 8; k++) begin
            if (!v[0]) put(0, 1'b0, 6'd3, 16'h0);
            if (!v[1]) put(1, 1'b0, 6'd7, 16'h0);
            cycle();
        end
        run_until_idle();

        // Out-of-range write and read, plus untouched in-range address
        put(1, 1'b1, 6'd20, 16'h1234);
        run_until_idle();
        put(1, 1'b0, 6'd20, 16'h0);
        run_until_idle();
        put(0, 1'b0, 6'd4, 16'h0);
        run_until_idle();
        cycle();

        // Reset during the response cycle of a read
        put(0, 1'b0, 6'd3, 16'h0);
        cycle();
        rst = 1'b1;
        q.delete();
        m_ptr   = 0;
        m_addrb = '0;
        put(0, 1'b0, 6'd3, 16'h0);
        @(negedge clk);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        v = '0;
        rst = 1'b0;
        cycle();
        put(1, 1'b0, 6'd7, 16'h0);
        put(0, 1'b0, 6'd3, 16'h0);
        run_until_idle();

        // Fill every word, then read back with idle gaps
        for (int i = 0; i < DEPTH; i++) begin
            put(i % N, 1'b1, AW'(i), DW'(16'h100 + i));
            run_until_idle();
        end
        for (int i = 0; i < DEPTH; i++) begin
            put(0, 1'b0, AW'(i), 16'h0);
            run_until_idle();
            cycle();
        end

`ifdef RAM_ARB_DUAL_ISSUE_EN
        // Same-address write and read in one cycle: read sees the old word
        put(0, 1'b1, 6'd5, 16'hAAAA);
        put(1, 1'b0, 6'd5, 16'h0);
        cycle();
        put(1, 1'b0, 6'd5, 16'h0);
        run_until_idle();
`endif

        repeat (3) cycle();
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Round-robin arbiter that shares the 16x16 simple dual-port RAM (write port A, registered read port B) between N_REQ requesters.
- Each requester gets a valid/ready request channel and a read-response channel.
- Sits between client blocks and the RAM. It drives the RAM's wr/dina/addra/addrb and consumes doutb.
- Tracks in-flight reads so each response is routed back to its owner.

Parameters:
- DATA_W, 16: data width; matches RAM dina/doutb.
- ADDR_W, 6: address width; matches RAM addra/addrb.
- DEPTH, 16: number of implemented RAM words. Addresses >= DEPTH are out of range.
- N_REQ, 2: number of requesters. Supported values 2..4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester request accepted this cycle
- req_wr  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_W  per-requester address, packed
- req_wdata  in  N_REQ*DATA_W  per-requester write data, packed
- rsp_valid  out  N_REQ  per-requester read response valid, 1-cycle pulse
- rsp_rdata  out  DATA_W  read data, shared, qualified by rsp_valid
- rsp_err  out  1  out-of-range read flag, qualified by rsp_valid
- ram_wr  out  1  RAM write enable
- ram_dina  out  DATA_W  RAM write data
- ram_addra  out  ADDR_W  RAM write address
- ram_addrb  out  ADDR_W  RAM read address
- ram_doutb  in  DATA_W  RAM registered read data

Behaviour:
- Reset values (asynchronous, while rst=1):
  - req_ready=0, rsp_valid=0, rsp_err=0, ram_wr=0.
  - Round-robin pointer rr_ptr=0; read-pending flag rd_pend=0; owner register rd_owner=0.
  - ram_addra, ram_addrb, ram_dina = 0.
- Arbitration: one grant per cycle (base mode).
  - Winner is the first asserted req_valid searching from rr_ptr upward, wrapping modulo N_REQ.
  - req_ready is combinational and one-hot on the winner; all zero if no valid.
  - A handshake occurs when valid & ready. On that handshake, rr_ptr <= winner+1, wrapping (N_REQ-1 -> 0).
  - If no handshake occurs, rr_ptr holds.
- Request hold: a requester must hold valid, wr, addr and wdata stable until ready. The arbiter never drops an unaccepted request.
- Write grant:
  - ram_wr=1, ram_addra=addr, ram_dina=wdata, all combinational in the grant cycle.
  - The RAM commits at that clock edge. No response is returned for writes.
- Read grant in cycle N:
  - ram_addrb=addr combinationally.
  - On that edge: rd_pend<=1, rd_owner<=winner.
  - In cycle N+1: rsp_valid[rd_owner]=1, rsp_rdata=ram_doutb. Read latency is exactly 1 cycle after the handshake.
  - rsp_valid is a registered pulse and has no backpressure; requesters must accept it.
- Back-to-back reads are allowed every cycle. The pending tracker is one deep because latency is fixed.
- Out-of-range (addr >= DEPTH):
  - Write: accepted with a handshake, but ram_wr is held 0 and the write is dropped.
  - Read: accepted; the response in cycle N+1 has rsp_rdata=0 and rsp_err=1.
  - In-range reads give rsp_err=0.
- Idle: when there is no grant, ram_wr=0. ram_addrb holds its previous value (registered hold mux) so ram_doutb remains stable.
- Read-after-write hazard: a read granted in the cycle after a write to the same address returns the new data, because the write committed at the earlier edge. No forwarding logic is needed.
- Reset mid-operation: any in-flight read response is discarded, and rsp_valid is never asserted after rst rises.

Optional Feature:
- Macro: RAM_ARB_DUAL_ISSUE_EN
- Defined: two grants are allowed per cycle, one write and one read, from different requesters. The RAM ports are independent.
  - Write search runs from rr_ptr. Read search runs from rr_ptr, skipping the write winner.
  - rr_ptr advances past the higher-priority of the two winners.
  - Same-address write and read in the same cycle: the read returns the OLD data (RAM read-before-write semantics).
- Undefined: base mode, single grant per cycle.

Decomposition:
- Package ram_arb_pkg holds:
  - constants DATA_W_C=16, ADDR_W_C=6, DEPTH_C=16;
  - typedef req_t, a struct of {wr, addr, wdata};
  - function rr_pick(valid, ptr), which returns the one-hot winner.
- Sub-module rr_picker: the combinational rotate-priority-rotate-back encoder. It is instantiated once in base mode, twice with dual-issue.

Test Plan:
- Write then read: R0 writes 0xBEEF at addr 3; next cycle R0 reads addr 3 -> rsp_valid[0] one cycle after the handshake, rsp_rdata=0xBEEF, rsp_err=0.
- Fairness: R0 and R1 both hold valid reads continuously for 8 cycles -> grants alternate 0,1,0,1,…; every rsp is routed to the correct owner with the correct data.
- Out-of-range: R1 writes 0x1234 at addr 20 -> ram_wr stays 0. R1 then reads addr 20 -> rsp_rdata=0, rsp_err=1. A read of addr 4 is unchanged (0 after reset).
- Reset mid-read: assert rst in the cycle after a read handshake -> no rsp_valid is produced; after release, req_ready=0 until a valid arrives and rr_ptr=0.
- Wrap and idle: fill addrs 0..15 with value=addr+0x100, then read back in order with idle gaps -> all 16 values match; ram_wr=0 in gap cycles.
- Dual-issue (macro defined): R0 writes 0xAAAA at addr 5 while R1 reads addr 5 in the same cycle -> R1 gets the old value. A subsequent read returns 0xAAAA. Both req_ready bits are high in that cycle.
